// File: rtl/fixed_to_bcd_ctrl.sv
// Fixed-point to BCD sequencer: splits a signed fixed-point value into sign,
// integer magnitude and fraction magnitude, launches the integer and fractional
// BCD converters together, gathers both results and presents one assembled
// result with a valid pulse (or an error pulse if a converter never answers).
module fixed_to_bcd_ctrl #(
  parameter int unsigned INT_BITS    = 8,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned INT_DIGITS  = 3,
  parameter int unsigned FRAC_DIGITS = 7,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           i_start,
  input  logic [INT_BITS+FRAC_BITS-1:0]  i_value,
  output logic                           o_busy,
  output logic                           o_int_ce,
  output logic [INT_BITS-1:0]            o_int_bin,
  input  logic [INT_DIGITS*4-1:0]        i_int_bcd,
  input  logic                           i_int_done,
  output logic                           o_frac_ce,
  output logic [FRAC_BITS-1:0]           o_frac_bin,
  input  logic [FRAC_DIGITS*4-1:0]       i_frac_bcd,
  input  logic                           i_frac_done,
  output logic                           o_sign,
  output logic [INT_DIGITS*4-1:0]        o_int_bcd,
  output logic [FRAC_DIGITS*4-1:0]       o_frac_bcd,
  output logic                           o_valid,
  output logic                           o_err
);

  localparam int unsigned W  = INT_BITS + FRAC_BITS;
  localparam int unsigned IW = INT_DIGITS * 4;
  localparam int unsigned FW = FRAC_DIGITS * 4;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_OUT,
    S_ERR
  } state_t;

  state_t         state;
  logic           sign_q;
  logic           int_flag;
  logic           frac_flag;
  logic [IW-1:0]  int_cap;
  logic [FW-1:0]  frac_cap;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   mag;
  logic [CW-1:0]  cnt_inc;
  logic           int_ok;
  logic           frac_ok;
  logic [IW-1:0]  int_nxt;
  logic [FW-1:0]  frac_nxt;

  // Magnitude of the input; the most-negative value maps to 2^(W-1) unsigned.
  assign mag = i_value[W-1] ? ((~i_value) + W'(1)) : i_value;

  // A done sampled on this edge counts as already captured, so a same-edge
  // completion goes straight to OUT with the live converter data.
  assign int_ok   = int_flag  | i_int_done;
  assign frac_ok  = frac_flag | i_frac_done;
  assign int_nxt  = int_flag  ? int_cap  : i_int_bcd;
  assign frac_nxt = frac_flag ? frac_cap : i_frac_bcd;
  assign cnt_inc  = cnt + CW'(1);

  // Sequencer: state, operand/capture registers and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      sign_q     <= 1'b0;
      int_flag   <= 1'b0;
      frac_flag  <= 1'b0;
      int_cap    <= '0;
      frac_cap   <= '0;
      cnt        <= '0;
      o_busy     <= 1'b0;
      o_int_ce   <= 1'b0;
      o_frac_ce  <= 1'b0;
      o_int_bin  <= '0;
      o_frac_bin <= '0;
      o_sign     <= 1'b0;
      o_int_bcd  <= '0;
      o_frac_bcd <= '0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_int_ce  <= 1'b0;
      o_frac_ce <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            sign_q     <= i_value[W-1];
            o_int_bin  <= mag[W-1:FRAC_BITS];
            o_frac_bin <= mag[FRAC_BITS-1:0];
            int_flag   <= 1'b0;
            frac_flag  <= 1'b0;
            cnt        <= '0;
            o_int_ce   <= 1'b1;
            o_frac_ce  <= 1'b1;
            o_busy     <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_int_done && !int_flag) begin
            int_cap  <= i_int_bcd;
            int_flag <= 1'b1;
          end
          if (i_frac_done && !frac_flag) begin
            frac_cap  <= i_frac_bcd;
            frac_flag <= 1'b1;
          end
          if (int_ok && frac_ok) begin
            o_sign     <= sign_q;
            o_int_bcd  <= int_nxt;
            o_frac_bcd <= frac_nxt;
            o_valid    <= 1'b1;
            state      <= S_OUT;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(TIMEOUT)) begin
              o_err <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_OUT, S_ERR: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_bcd_ctrl.sv
// Self-checking bench for fixed_to_bcd_ctrl with behavioural converter models.
module tb_fixed_to_bcd_ctrl;

  localparam int TO = 20;

  logic        CLK;
  logic        RST;
  logic        i_start;
  logic [15:0] i_value;
  logic        o_busy;
  logic        o_int_ce;
  logic [7:0]  o_int_bin;
  logic [11:0] i_int_bcd;
  logic        i_int_done;
  logic        o_frac_ce;
  logic [7:0]  o_frac_bin;
  logic [27:0] i_frac_bcd;
  logic        i_frac_done;
  logic        o_sign;
  logic [11:0] o_int_bcd;
  logic [27:0] o_frac_bcd;
  logic        o_valid;
  logic        o_err;

  fixed_to_bcd_ctrl #(
    .INT_BITS(8), .FRAC_BITS(8), .INT_DIGITS(3), .FRAC_DIGITS(7), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .i_start(i_start), .i_value(i_value),
    .o_busy(o_busy),
    .o_int_ce(o_int_ce), .o_int_bin(o_int_bin), .i_int_bcd(i_int_bcd), .i_int_done(i_int_done),
    .o_frac_ce(o_frac_ce), .o_frac_bin(o_frac_bin), .i_frac_bcd(i_frac_bcd), .i_frac_done(i_frac_done),
    .o_sign(o_sign), .o_int_bcd(o_int_bcd), .o_frac_bcd(o_frac_bcd),
    .o_valid(o_valid), .o_err(o_err)
  );

  typedef struct {
    logic [15:0] val;
    int          idly;
    int          fdly;
    logic        sign;
    logic [11:0] ib;
    logic [27:0] fb;
    logic [7:0]  bi;
    logic [7:0]  bf;
  } vec_t;

  typedef struct {
    logic        sign;
    logic [11:0] ib;
    logic [27:0] fb;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int ce_cnt = 0;
  int both_cnt = 0;

  int int_dly, frac_dly;
  bit frac_never;
  int stray_cnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters sampled on the active edge.
  always @(posedge CLK) begin
    valid_cnt <= valid_cnt + int'(o_valid);
    err_cnt   <= err_cnt + int'(o_err);
    ce_cnt    <= ce_cnt + int'(o_int_ce | o_frac_ce);
    both_cnt  <= both_cnt + int'(o_valid & o_err);
  end

  function automatic logic [31:0] to_bcd(input longint unsigned v, input int nd);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter models: done arrives dly WAIT cycles after the first WAIT cycle.
  initial begin
    bit int_act, frac_act;
    int int_t, frac_t, stray_seen;
    longint unsigned fv;
    int_act = 0; frac_act = 0; int_t = 0; frac_t = 0; stray_seen = 0;
    i_int_bcd = '0; i_frac_bcd = '0;
    forever begin
      @(negedge CLK);
      i_int_done = 1'b0;
      i_frac_done = 1'b0;
      if (RST) begin
        int_act = 0;
        frac_act = 0;
      end else begin
        if (int_act) begin
          if (int_t == 0) begin
            i_int_done = 1'b1;
            i_int_bcd = 12'(to_bcd(64'(o_int_bin), 3));
            int_act = 0;
          end else int_t--;
        end
        if (frac_act) begin
          if (frac_t == 0) begin
            fv = (64'(o_frac_bin) * 64'd10000000) >> 8;
            i_frac_done = 1'b1;
            i_frac_bcd = 28'(to_bcd(fv, 7));
            frac_act = 0;
          end else frac_t--;
        end
        if (stray_cnt != stray_seen) begin
          stray_seen = stray_cnt;
          i_int_done = 1'b1;
          i_int_bcd = 12'h999;
        end
        if (o_int_ce) begin
          int_act = 1;
          int_t = int_dly;
        end
        if (o_frac_ce && !frac_never) begin
          frac_act = 1;
          frac_t = frac_dly;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One conversion; ok=0 expects a timeout. poke>0 pulses i_start in that WAIT cycle.
  task automatic run_job(input logic [15:0] val, input int idly, input int fdly,
                         input logic es, input logic [11:0] ei, input logic [27:0] ef,
                         input logic [7:0] bi, input logic [7:0] bf, input bit ok, input int poke);
    int cyc, lat, v0, e0, c0;
    logic ps;
    logic [11:0] pi;
    logic [27:0] pf;
    exp_t e;
    v0 = valid_cnt; e0 = err_cnt; c0 = ce_cnt;
    ps = o_sign; pi = o_int_bcd; pf = o_frac_bcd;
    int_dly = idly; frac_dly = fdly;
    if (ok) begin
      e.sign = es; e.ib = ei; e.fb = ef;
      exp_q.push_back(e);
    end
    i_value = val;
    i_start = 1'b1;
    @(negedge CLK);
    i_start = 1'b0;
    chk("launch_ce_busy", 64'({o_int_ce, o_frac_ce, o_busy}), 64'h7);
    chk("bins", 64'({o_int_bin, o_frac_bin}), 64'({bi, bf}));
    cyc = 0;
    while (cyc < 200 && !o_valid && !o_err) begin
      @(negedge CLK);
      cyc++;
      i_start = (cyc == poke);
    end
    i_start = 1'b0;
    lat = ok ? 2 + ((idly > fdly) ? idly : fdly) : 1 + TO;
    chk("latency", 64'(cyc), 64'(lat));
    chk("outcome", 64'({o_valid, o_err}), ok ? 64'h2 : 64'h1);
    chk("bins_hold", 64'({o_int_bin, o_frac_bin}), 64'({bi, bf}));
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result", 64'({o_sign, o_int_bcd, o_frac_bcd}), 64'({e.sign, e.ib, e.fb}));
    end else if (!ok) begin
      chk("result_kept", 64'({o_sign, o_int_bcd, o_frac_bcd}), 64'({ps, pi, pf}));
    end
    @(negedge CLK);
    chk("idle_after", 64'({o_busy, o_valid, o_err}), 64'h0);
    chk("pulse_counts", 64'({16'(valid_cnt - v0), 16'(err_cnt - e0), 16'(ce_cnt - c0)}),
        64'({16'(ok ? 1 : 0), 16'(ok ? 0 : 1), 16'd1}));
  endtask

  initial begin
    int v0, e0, c0;
    logic [11:0] pi;
    RST = 1'b1; i_start = 1'b0; i_value = '0;
    int_dly = 0; frac_dly = 0; frac_never = 0; stray_cnt = 0;

    vecs[0] = '{16'h0380,  0, 0, 1'b0, 12'h003, 28'h5000000, 8'h03, 8'h80};
    vecs[1] = '{16'hFC80,  2, 1, 1'b1, 12'h003, 28'h5000000, 8'h03, 8'h80};
    vecs[2] = '{16'h8000,  1, 3, 1'b1, 12'h128, 28'h0000000, 8'h80, 8'h00};
    vecs[3] = '{16'h0000,  2, 2, 1'b0, 12'h000, 28'h0000000, 8'h00, 8'h00};
    vecs[4] = '{16'h0140,  0, 4, 1'b0, 12'h001, 28'h2500000, 8'h01, 8'h40};
    vecs[5] = '{16'hFEC0,  3, 0, 1'b1, 12'h001, 28'h2500000, 8'h01, 8'h40};
    vecs[6] = '{16'h7FFF,  5, 5, 1'b0, 12'h127, 28'h9960937, 8'h7F, 8'hFF};
    vecs[7] = '{16'hFFFF,  1, 0, 1'b1, 12'h000, 28'h0039062, 8'h00, 8'h01};
    vecs[8] = '{16'h0380, 19, 0, 1'b0, 12'h003, 28'h5000000, 8'h03, 8'h80};

    #12;
    chk("reset_ctrl", 64'({o_busy, o_int_ce, o_frac_ce, o_valid, o_err, o_sign}), 64'h0);
    chk("reset_data", 64'({o_int_bin, o_frac_bin, o_int_bcd, o_frac_bcd}), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 9; i++)
      run_job(vecs[i].val, vecs[i].idly, vecs[i].fdly, vecs[i].sign, vecs[i].ib,
              vecs[i].fb, vecs[i].bi, vecs[i].bf, 1'b1, 0);

    // Fractional converter never answers: timeout, previous result kept.
    frac_never = 1;
    run_job(16'h0140, 2, 0, 1'b0, 12'h0, 28'h0, 8'h01, 8'h40, 1'b0, 0);
    frac_never = 0;

    // Start pulse during WAIT is ignored.
    run_job(16'hFEC0, 6, 6, 1'b1, 12'h001, 28'h2500000, 8'h01, 8'h40, 1'b1, 3);

    // Stray integer done while idle is ignored.
    v0 = valid_cnt; e0 = err_cnt; c0 = ce_cnt; pi = o_int_bcd;
    stray_cnt++;
    repeat (4) @(negedge CLK);
    chk("stray_idle", 64'({16'(valid_cnt - v0), 16'(err_cnt - e0), 16'(ce_cnt - c0), 4'(o_busy), pi}),
        64'({16'd0, 16'd0, 16'd0, 4'd0, o_int_bcd}));
    chk("stray_bcd_kept", 64'(o_int_bcd), 64'h001);
    run_job(16'h0380, 6, 0, 1'b0, 12'h003, 28'h5000000, 8'h03, 8'h80, 1'b1, 0);

    // Reset in the middle of WAIT.
    int_dly = 8; frac_dly = 8;
    i_value = 16'h8000;
    i_start = 1'b1;
    @(negedge CLK);
    i_start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_reset_busy", 64'(o_busy), 64'h1);
    v0 = valid_cnt; e0 = err_cnt; c0 = ce_cnt;
    #2 RST = 1'b1;
    #1;
    chk("async_rst_ctrl", 64'({o_busy, o_int_ce, o_frac_ce, o_valid, o_err, o_sign}), 64'h0);
    chk("async_rst_data", 64'({o_int_bin, o_frac_bin, o_int_bcd, o_frac_bcd}), 64'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    chk("post_rst_quiet", 64'({16'(valid_cnt - v0), 16'(err_cnt - e0), 16'(ce_cnt - c0), 4'(o_busy)}),
        64'h0);
    run_job(16'hFFFF, 1, 0, 1'b1, 12'h000, 28'h0039062, 8'h00, 8'h01, 1'b1, 0);

    chk("valid_err_both", 64'(both_cnt), 64'h0);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
